// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 inverse cipher.
package aes_pkg;

  localparam int NR_128 = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte r+4c lives at d[127-8*(r+4c) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-32*c -: 8];
      a1 = d[119-32*c -: 8];
      a2 = d[111-32*c -: 8];
      a3 = d[103-32*c -: 8];
      o[127-32*c -: 32] = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                           gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                           gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                           gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte, combinational lookup table.
module inv_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign sbox_out = INV_SBOX[sbox_in];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core, one round per clock, round keys fetched by index.
// Define AES_DEC_BACK2BACK_EN to accept the next block in the cycle the result is taken.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  if (NR != NR_128) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
  end

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [127:0] state_q;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic [127:0] ark;
  logic [127:0] ld_blk;

  assign sb_in  = inv_shift_rows(state_q);
  assign ark    = sb_out ^ rk;
  assign ld_blk = ciphertext ^ rk;
  assign busy   = (fsm != IDLE);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .sbox_in  (sb_in[127-8*i -: 8]),
      .sbox_out (sb_out[127-8*i -: 8])
    );
  end

`ifdef AES_DEC_BACK2BACK_EN
  assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
`else
  assign in_ready = (fsm == IDLE);
`endif

  // rk_idx tracks rnd in RUN and parks at 10 elsewhere so a load sees the last round key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= 4'd0;
      state_q   <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
      rk_idx    <= 4'd10;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q <= ld_blk;
            rnd     <= 4'(NR - 1);
            rk_idx  <= 4'(NR - 1);
            fsm     <= RUN;
          end
        end
        RUN: begin
          if (rnd != 4'd0) begin
            state_q <= inv_mix_columns(ark);
            rnd     <= rnd - 4'd1;
            rk_idx  <= rnd - 4'd1;
          end else begin
            plaintext <= ark;
            out_valid <= 1'b1;
            rk_idx    <= 4'(NR);
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
`ifdef AES_DEC_BACK2BACK_EN
            if (in_valid) begin
              state_q <= ld_blk;
              rnd     <= 4'(NR - 1);
              rk_idx  <= 4'(NR - 1);
              fsm     <= RUN;
            end
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, random blocks, backpressure, reset.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rks   [0:10];

  always #5 clk = ~clk;

  assign rk = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

  aes_inv_cipher_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] coef [4];
    logic [127:0] out;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rks[10][127-8*i -: 8];
    for (int round = 9; round >= 0; round--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ rks[round][127-8*i -: 8];
      if (round > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            t[r + 4*c] = 8'h00;
            for (int k = 0; k < 4; k++) t[r + 4*c] = t[r + 4*c] ^ gm(coef[(k - r + 4) % 4], s[k + 4*c]);
          end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic accept(input logic [127:0] ct, output logic [3:0] rk_pre);
    int k;
    k = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = ct;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    rk_pre = rk_idx;
    @(posedge clk);
  endtask

  task automatic run_block(input logic [127:0] ct, input bit hold_iv, input int bp,
                           output logic [127:0] pt_obs);
    int          n;
    logic [3:0]  rk_pre;
    logic [43:0] seq;
    logic [43:0] eseq;
    logic        stable;
    eseq = '0;
    for (int i = 0; i <= 10; i++) eseq = {eseq[39:0], 4'(10 - i)};
    accept(ct, rk_pre);
    @(negedge clk);
    if (hold_iv) ciphertext = ~ct;
    else in_valid = 1'b0;
    seq = {40'h0, rk_pre};
    n = 0;
    while (!out_valid && n < 40) begin
      if (n < 10) seq = {seq[39:0], rk_idx};
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(n), 128'(10));
    chk("rk_idx_seq", 128'(seq), 128'(eseq));
    chk("busy_done", 128'(busy), 128'(1));
    pt_obs = plaintext;
    chk("pt_model", plaintext, ref_dec(ct));
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (plaintext !== pt_obs || !out_valid || in_ready) stable = 1'b0;
    end
    if (bp > 0) chk("backpressure_hold", 128'(stable), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 128'(out_valid), 128'(0));
    chk("idle_after", 128'(busy), 128'(0));
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [3:0]   rk_pre;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    build_sbox();
    set_key(KEY_B);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_rk_idx", 128'(rk_idx), 128'(10));
    chk("rst_plaintext", plaintext, 128'(0));
    rst_n = 1'b1;

    run_block(CT_B, 1'b0, 0, pt);
    chk("fips_b", pt, PT_B);

    set_key(KEY_C);
    run_block(CT_C, 1'b0, 20, pt);
    chk("fips_c", pt, PT_C);

    set_key(KEY_B);
    run_block(CT_B, 1'b1, 2, pt);
    chk("hold_iv_pt", pt, PT_B);

    accept(CT_B, rk_pre);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_rk_idx", 128'(rk_idx), 128'(10));
    @(negedge clk);
    rst_n = 1'b1;
    run_block(CT_B, 1'b0, 1, pt);
    chk("fips_b_after_rst", pt, PT_B);

    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      run_block(ct, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), pt);
    end

`ifdef AES_DEC_BACK2BACK_EN
    begin
      logic [127:0] ct1;
      logic [127:0] ct2;
      int n;
      set_key(KEY_C);
      ct1 = {$urandom, $urandom, $urandom, $urandom};
      ct2 = {$urandom, $urandom, $urandom, $urandom};
      accept(ct1, rk_pre);
      @(negedge clk);
      ciphertext = ct2;
      out_ready  = 1'b1;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_latency1", 128'(n), 128'(10));
      chk("b2b_pt1", plaintext, ref_dec(ct1));
      chk("b2b_in_ready", 128'(in_ready), 128'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_reaccept_valid", 128'(out_valid), 128'(0));
      chk("b2b_reaccept_busy", 128'(busy), 128'(1));
      chk("b2b_reaccept_rk_idx", 128'(rk_idx), 128'(9));
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_latency2", 128'(n), 128'(10));
      chk("b2b_pt2", plaintext, ref_dec(ct2));
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_drop", 128'(out_valid), 128'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
